// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational fetch-stage lookup,
// MEM-stage update and allocation, and a registered misprediction pulse and counter.
package my_pkg;
  typedef struct packed {
    logic        v;
    logic [5:0]  tag;
    logic [31:0] ta;
    logic        t;
  } cache_branch_t;
endpackage

module branch_target_buffer
  import my_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        flush_all,
  output logic        mispredict,
  output logic [31:0] mispredict_cnt
);
  localparam int IDXW = $clog2(ENTRIES);

  // upd_valid is a one-cycle qualifier with no back-pressure: every cycle it is
  // high, the upd_* fields describe one resolved branch and are consumed at that edge.
  cache_branch_t entries [ENTRIES];

  logic [IDXW-1:0] if_idx;
  logic [IDXW-1:0] upd_idx;
  logic [5:0]      if_tag;
  logic [5:0]      upd_tag;
  cache_branch_t   if_entry;
  cache_branch_t   upd_entry;
  logic            upd_hit;
  logic            mp_cond;
  logic [31:0]     cnt_q;
  logic            unused_bits;

  assign if_idx  = if_pc[2+IDXW-1:2];
  assign if_tag  = if_pc[2+IDXW+5:2+IDXW];
  assign upd_idx = upd_pc[2+IDXW-1:2];
  assign upd_tag = upd_pc[2+IDXW+5:2+IDXW];

  assign unused_bits = ^{if_pc[31:IDXW+8], if_pc[1:0], upd_pc[31:IDXW+8], upd_pc[1:0]};

  // Lookup sees only committed state; a same-cycle update is not forwarded.
  assign if_entry    = entries[if_idx];
  assign pred_hit    = if_entry.v && (if_entry.tag == if_tag);
  assign pred_taken  = pred_hit && if_entry.t;
  assign pred_target = pred_hit ? if_entry.ta : 32'h0;

  assign upd_entry = entries[upd_idx];
  assign upd_hit   = upd_entry.v && (upd_entry.tag == upd_tag);

  assign mp_cond = (upd_taken != upd_pred_taken) ||
                   (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].v <= 1'b0;
        entries[i].t <= 1'b0;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].v <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        entries[upd_idx].t <= upd_taken;
        if (upd_taken) begin
          entries[upd_idx].ta <= upd_target;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        entries[upd_idx] <= '{v: 1'b1, tag: upd_tag, ta: upd_target, t: 1'b1};
      end
    end
  end

  // Misprediction accounting ignores flush_all; only rst suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      mispredict <= upd_valid && mp_cond;
      if (upd_valid && mp_cond) begin
        cnt_q <= cnt_q + 32'h1;
      end
    end
  end

  assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: the driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_branch_target_buffer;
  localparam int W = 67;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush_all;
  logic        mispredict;
  logic [31:0] mispredict_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk;
  int           compared;
  int           mismatched;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush_all       (flush_all),
    .mispredict      (mispredict),
    .mispredict_cnt  (mispredict_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input logic r, input logic fl, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    rst             = r;
    flush_all       = fl;
    if_pc           = pc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
  endtask

  task automatic lookup_only(input logic [31:0] pc);
    drive(1'b0, 1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic expect_out(input string name, input logic hit, input logic taken,
                            input logic [31:0] tgt, input logic mp, input logic [31:0] cnt);
    exp_q.push_back({hit, taken, tgt, mp, cnt});
    name_q.push_back(name);
    chk = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (chk) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string        n;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL queue_underflow: check requested with no expectation queued");
      end else begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        got = {pred_hit, pred_taken, pred_target, mispredict, mispredict_cnt};
        if (got !== e) begin
          mismatched++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h mp=%0b cnt=%h, expected hit=%0b taken=%0b target=%h mp=%0b cnt=%h",
                   n, got[66], got[65], got[64:33], got[32], got[31:0],
                   e[66], e[65], e[64:33], e[32], e[31:0]);
        end
      end
    end
  end

  // Directed sequence
  initial begin
    compared   = 0;
    mismatched = 0;
    chk        = 1'b0;
    drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("reset_lookup", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    expect_out("alloc_same_cycle_old", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    lookup_only(32'h100);
    expect_out("alloc_hit", 1'b1, 1'b1, 32'h200, 1'b1, 32'h1);
    next_cycle();

    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h999, 1'b1, 32'h200);
    expect_out("not_taken_same_cycle", 1'b1, 1'b1, 32'h200, 1'b0, 32'h1);
    next_cycle();

    lookup_only(32'h100);
    expect_out("not_taken_hit_ta_held", 1'b1, 1'b0, 32'h200, 1'b1, 32'h2);
    next_cycle();

    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    expect_out("target_mp_same_cycle", 1'b1, 1'b0, 32'h200, 1'b0, 32'h2);
    next_cycle();

    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h300);
    expect_out("target_mp_retarget", 1'b1, 1'b1, 32'h300, 1'b1, 32'h3);
    next_cycle();

    drive(1'b0, 1'b0, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("correct_pred_no_pulse", 1'b0, 1'b0, 32'h0, 1'b0, 32'h3);
    next_cycle();

    lookup_only(32'h100);
    expect_out("nt_miss_no_evict", 1'b1, 1'b1, 32'h300, 1'b0, 32'h3);
    next_cycle();

    drive(1'b0, 1'b0, 32'h140, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
    expect_out("nt_miss_no_alloc", 1'b0, 1'b0, 32'h0, 1'b0, 32'h3);
    next_cycle();

    lookup_only(32'h100);
    expect_out("alias_old_evicted", 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
    next_cycle();

    drive(1'b0, 1'b0, 32'h500, 1'b1, 32'h104, 1'b1, 32'h800, 1'b1, 32'h800);
    expect_out("alias_new_hit", 1'b1, 1'b1, 32'h600, 1'b0, 32'h4);
    next_cycle();

    drive(1'b0, 1'b1, 32'h104, 1'b1, 32'h108, 1'b1, 32'hA00, 1'b0, 32'h0);
    expect_out("flush_same_cycle", 1'b1, 1'b1, 32'h800, 1'b0, 32'h4);
    next_cycle();

    lookup_only(32'h104);
    expect_out("flush_cleared", 1'b0, 1'b0, 32'h0, 1'b1, 32'h5);
    next_cycle();

    lookup_only(32'h108);
    expect_out("flush_beats_update", 1'b0, 1'b0, 32'h0, 1'b0, 32'h5);
    next_cycle();

    lookup_only(32'h500);
    expect_out("flush_alias_cleared", 1'b0, 1'b0, 32'h0, 1'b0, 32'h5);
    next_cycle();

    drive(1'b0, 1'b0, 32'h10C, 1'b1, 32'h10C, 1'b1, 32'hC00, 1'b0, 32'h0);
    expect_out("realloc_same_cycle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h5);
    next_cycle();

    drive(1'b1, 1'b0, 32'h10C, 1'b1, 32'h110, 1'b1, 32'hE00, 1'b0, 32'h0);
    expect_out("pre_reset_state", 1'b1, 1'b1, 32'hC00, 1'b1, 32'h6);
    next_cycle();

    lookup_only(32'h10C);
    expect_out("reset_beats_update", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    drive(1'b0, 1'b0, 32'h110, 1'b1, 32'h114, 1'b0, 32'h0, 1'b1, 32'h0);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    expect_out("cnt_preload", 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    next_cycle();

    lookup_only(32'h114);
    expect_out("cnt_wrap", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    next_cycle();

    lookup_only(32'h100);
    expect_out("pulse_one_cycle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    repeat (2) next_cycle();
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
